// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide, one bit per cycle, with a stall request while an op runs.
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            md_en,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      waddr_in,
    input  logic            hold,
    output logic            stall_req,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      waddr_out
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [2:0]          op_r;
    logic [4:0]          waddr_r;
    logic [XLEN-1:0]     a_mag, b_mag, result_r;
    logic                neg_r, rem_neg_r;
    logic [2*XLEN-1:0]   acc, acc_nx;

    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cneg_w(input logic [2*XLEN-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    // Operand decode, evaluated in IDLE
    logic            is_div, rs1_signed, rs2_signed, rs1_neg, rs2_neg;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] rs1_mag, rs2_mag, special_res;

    always_comb begin
        is_div      = md_op[2];
        rs1_signed  = is_div ? ~md_op[0] : (md_op != 3'd3);
        rs2_signed  = is_div ? ~md_op[0] : ~md_op[1];
        rs1_neg     = rs1_signed & rs1_data[XLEN-1];
        rs2_neg     = rs2_signed & rs2_data[XLEN-1];
        rs1_mag     = cneg(rs1_data, rs1_neg);
        rs2_mag     = cneg(rs2_data, rs2_neg);
        div_zero    = is_div && (rs2_data == '0);
        div_ovf     = is_div && ~md_op[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                      && (rs2_data == '1);
        special     = div_zero | div_ovf;
        // Overflow: quotient equals the dividend (most negative value), remainder zero
        if (div_zero)
            special_res = md_op[1] ? rs1_data : '1;
        else
            special_res = md_op[1] ? '0 : rs1_data;
    end

    // One iteration of shift-add multiply or restoring divide
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic            div_ge;
    logic [XLEN-1:0] div_rem, mul_res, div_res;
    logic [2*XLEN-1:0] mul_acc_nx, div_acc_nx, mul_prod;
    logic            last;

    always_comb begin
        mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : {(XLEN+1){1'b0}});
        mul_acc_nx = {mul_sum, acc[XLEN-1:1]};
        div_shift  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff   = div_shift - {1'b0, b_mag};
        div_ge     = ~div_diff[XLEN];
        div_rem    = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        div_acc_nx = {div_rem, acc[XLEN-2:0], div_ge};
        acc_nx     = (state == MUL) ? mul_acc_nx : div_acc_nx;
        mul_prod   = cneg_w(mul_acc_nx, neg_r);
        mul_res    = (op_r[1:0] == 2'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
        div_res    = op_r[1] ? cneg(div_rem, rem_neg_r) : cneg(div_acc_nx[XLEN-1:0], neg_r);
        last       = (cnt == CNT_W'(XLEN-1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (busy && !last) ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nx     = state;
        stall_req    = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        unique case (state)
            IDLE: begin
                stall_req = md_en;
                if (md_en)
                    state_nx = special ? DONE : (is_div ? DIV : MUL);
            end
            MUL, DIV: begin
                stall_req = 1'b1;
                busy      = 1'b1;
                if (last)
                    state_nx = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                if (!hold)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch and iteration datapath
    always_ff @(posedge clk) begin
        if (state == IDLE && md_en) begin
            a_mag     <= rs1_mag;
            b_mag     <= rs2_mag;
            op_r      <= md_op;
            neg_r     <= rs1_neg ^ rs2_neg;
            rem_neg_r <= rs1_neg;
            acc       <= {{XLEN{1'b0}}, is_div ? rs1_mag : rs2_mag};
        end else if (busy) begin
            acc <= acc_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= '0;
            waddr_r  <= '0;
        end else if (state == IDLE && md_en) begin
            waddr_r <= waddr_in;
            if (special)
                result_r <= special_res;
        end else if (busy && last) begin
            result_r <= (state == MUL) ? mul_res : div_res;
        end
    end

    assign result    = result_r;
    assign waddr_out = waddr_r;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: expected results queued at issue, checked on result_valid.
module tb_ex_muldiv;
    logic        clk, rst, md_en, hold;
    logic [2:0]  md_op;
    logic [31:0] rs1_data, rs2_data;
    logic [4:0]  waddr_in;
    logic        stall_req, busy, result_valid;
    logic [31:0] result;
    logic [4:0]  waddr_out;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
        int          lat;
    } exp_t;
    exp_t sb[$];

    ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .md_en(md_en), .md_op(md_op),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .waddr_in(waddr_in),
        .hold(hold), .stall_req(stall_req), .busy(busy),
        .result_valid(result_valid), .result(result), .waddr_out(waddr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wa,
                          input logic [31:0] exp_res, input int exp_lat, input int hold_n);
        exp_t e;
        int   cyc;
        int   bad;
        sb.push_back('{exp_res, wa, exp_lat});
        md_op = op; rs1_data = a; rs2_data = b; waddr_in = wa; md_en = 1'b1;
        #1;
        cyc = 0;
        bad = 0;
        while (!result_valid && cyc < 40) begin
            if (stall_req !== 1'b1 || busy !== (cyc != 0)) bad++;
            step();
            md_en = 1'b0;
            rs1_data = $urandom; rs2_data = $urandom;
            waddr_in = 5'($urandom); md_op = 3'($urandom);
            #1;
            cyc++;
        end
        e = sb.pop_front();
        chk({tag, "_latency"}, cyc, e.lat);
        chk({tag, "_stall_busy_run"}, bad, 0);
        chk({tag, "_result"}, result, e.res);
        chk({tag, "_waddr"}, 32'(waddr_out), 32'(e.wa));
        chk({tag, "_done_stall_busy"}, 32'({stall_req, busy}), 0);
        for (int i = 0; i < hold_n; i++) begin
            hold = 1'b1;
            md_en = 1'b1;
            step();
            #1;
            chk({tag, "_hold_state"}, 32'({result_valid, stall_req, busy}), 32'b100);
            chk({tag, "_hold_result"}, result, e.res);
        end
        hold = 1'b0;
        md_en = 1'b0;
        step();
        #1;
        chk({tag, "_valid_drop"}, 32'(result_valid), 0);
    endtask

    initial begin
        rst = 1'b1; md_en = 1'b0; hold = 1'b0; md_op = 3'd0;
        rs1_data = '0; rs2_data = '0; waddr_in = '0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_ctrl", 32'({stall_req, busy, result_valid}), 0);
        chk("rst_result", result, 0);
        chk("rst_waddr", 32'(waddr_out), 0);

        run_op("mul",     3'd0, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33, 0);
        run_op("mulh",    3'd1, 32'h80000000,   32'h80000000, 5'd6,  32'h40000000, 33, 0);
        run_op("mulhu",   3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 33, 0);
        run_op("mulhsu",  3'd2, 32'hFFFFFFFF,   32'd2,        5'd8,  32'hFFFFFFFF, 33, 0);
        run_op("divu_z",  3'd5, 32'd100,        32'd0,        5'd9,  32'hFFFFFFFF, 1,  0);
        run_op("remu_z",  3'd7, 32'd100,        32'd0,        5'd10, 32'd100,      1,  0);
        run_op("div_ovf", 3'd4, 32'h80000000,   32'hFFFFFFFF, 5'd11, 32'h80000000, 1,  0);
        run_op("rem_ovf", 3'd6, 32'h80000000,   32'hFFFFFFFF, 5'd12, 32'd0,        1,  0);
        run_op("div_z",   3'd4, 32'hFFFFFFFB,   32'd0,        5'd13, 32'hFFFFFFFF, 1,  0);
        run_op("rem_z",   3'd6, 32'hFFFFFFFB,   32'd0,        5'd14, 32'hFFFFFFFB, 1,  0);
        run_op("div",     3'd4, 32'hFFFFFFF9,   32'd2,        5'd15, 32'hFFFFFFFD, 33, 0);
        run_op("rem",     3'd6, 32'hFFFFFFF9,   32'd2,        5'd16, 32'hFFFFFFFF, 33, 0);
        run_op("divu",    3'd5, 32'hFFFFFFF9,   32'd2,        5'd17, 32'h7FFFFFFC, 33, 0);
        run_op("remu",    3'd7, 32'd1000,       32'd7,        5'd18, 32'd6,        33, 0);
        run_op("mul_hold",3'd0, 32'd6,          32'd7,        5'd19, 32'd42,       33, 3);

        // Reset in the middle of a divide
        md_op = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3; waddr_in = 5'd20; md_en = 1'b1;
        #1;
        for (int k = 1; k <= 10; k++) begin
            step();
            md_en = 1'b0;
        end
        #1;
        chk("mid_div_busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'({stall_req, busy, result_valid}), 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_waddr", 32'(waddr_out), 0);

        run_op("mul_after_rst", 3'd0, 32'd3, 32'd4, 5'd21, 32'd12, 33, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, alongside the ALU.
- Takes operands, write address and M-op select straight from the ID/EX pipeline register outputs.
- While an operation runs it raises a stall request, so ID/EX and all upstream stages hold the instruction.
- Produces a one-cycle-valid 32-bit result with its destination register, for EX/MEM capture.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high. Clock is clk.
- md_en  in  1  instruction in EX is an M-extension op (opcode 0110011, funct7 0000001).
- md_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_data  in  XLEN  operand 1, forwarded value from ID/EX.
- rs2_data  in  XLEN  operand 2.
- waddr_in  in  5  destination register.
- hold  in  1  downstream stall (EX/MEM not accepting this cycle).
- stall_req  out  1  request that ID/EX and upstream stages hold.
- busy  out  1  state is MUL or DIV.
- result_valid  out  1  result/waddr_out valid this cycle; EX muxes result onto its write-data path.
- result  out  XLEN  operation result.
- waddr_out  out  5  latched destination register.

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset (any state, including mid-operation): state=IDLE, counter=0. Outputs: stall_req=0, busy=0, result_valid=0, result=0, waddr_out=0. Partial results are discarded.
- IDLE:
  - stall_req = md_en (combinational).
  - On md_en: latch operand magnitudes, result sign, op and waddr_in.
  - Next state is MUL for op 0-3, DIV for op 4-7, or DONE for the special cases below.
- Signed handling:
  - Signed operands are converted to magnitude. MULHSU treats rs1 as signed and rs2 as unsigned.
  - The product or quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
- MUL: 64-bit shift-add, one multiplier bit per cycle, XLEN cycles.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- DIV: restoring division, one quotient bit per cycle, XLEN cycles.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases go IDLE to DONE directly, with no iterations:
  - divisor==0: quotient=0xFFFFFFFF, remainder=rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
- In MUL/DIV: stall_req=1, busy=1. The counter increments each cycle; on counter==XLEN-1, go to DONE.
- DONE:
  - result_valid=1, stall_req=0, result and waddr_out driven from internal registers.
  - If hold=1: stay in DONE with all outputs stable.
  - If hold=0: go to IDLE next cycle, result_valid drops.
  - md_en is ignored in DONE. The pipeline advances in that cycle, so the held instruction is never restarted.
- Latency (md_en seen in IDLE at cycle 0):
  - Iterative ops: result_valid at cycle XLEN+1 (33). stall_req is high for cycles 0..32.
  - Special cases: result_valid at cycle 1. stall_req is high only in cycle 0.
- Back-to-back M-ops: the second is accepted in the IDLE cycle after DONE, with no bubble beyond that.
- Operand inputs may change during MUL/DIV. Only values latched in IDLE are used.
- Between operations, result and waddr_out retain their last values; only result_valid qualifies them.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, waddr=5 -> stall_req high for cycles 0-32; cycle 33 result_valid=1, result=0xFFFFFFEB, waddr_out=5; cycle 34 result_valid=0.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIVU 100/0 -> cycle 1 result=0xFFFFFFFF. REMU 100%0 -> 100. DIV 0x80000000/0xFFFFFFFF -> cycle 1 result=0x80000000. REM same operands -> 0.
- DIV -7/2 -> 0xFFFFFFFD. REM -7%2 -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC. Each valid at cycle 33.
- hold=1 for 3 cycles during DONE of MUL 6x7 -> result_valid=1, result=42 stable for 4 cycles, stall_req=0 throughout. Then IDLE.
- rst asserted at cycle 10 of a DIV, with md_en then low -> next cycle state IDLE, all outputs 0. A new MUL 3x4 afterwards -> 12 at cycle 33 after acceptance.
